// File: rtl/sd_cmd_scheduler_if.sv
// Request/response and CMD-line handshake bundle between the SD command scheduler,
// its two requesters and the shared CMD transmitter/receiver.
interface sd_cmd_scheduler_if;
    logic [1:0]   req_valid;
    logic [75:0]  req_cmd;
    logic [3:0]   req_rtype;
    logic [1:0]   req_ack;
    logic [1:0]   done;
    logic [1:0]   status;
    logic [126:0] resp_out;
    logic         send_en;
    logic [37:0]  send_cmd_content;
    logic         R2_response;
    logic         sd_cmd_sending;
    logic         sd_receive_finished;
    logic         crc_response_err;
    logic [126:0] response;

    modport master (
        input  req_valid, req_cmd, req_rtype,
        input  sd_cmd_sending, sd_receive_finished, crc_response_err, response,
        output req_ack, done, status, resp_out,
        output send_en, send_cmd_content, R2_response
    );

    modport slave (
        output req_valid, req_cmd, req_rtype,
        output sd_cmd_sending, sd_receive_finished, crc_response_err, response,
        input  req_ack, done, status, resp_out,
        input  send_en, send_cmd_content, R2_response
    );
endinterface

// File: rtl/sd_cmd_scheduler.sv
// Round-robin arbiter for the shared SD CMD line: issues one command at a time, waits for
// the response with timeout, retries on CRC error/timeout and enforces the inter-command gap.
module sd_cmd_scheduler #(
    parameter int unsigned RESP_TIMEOUT = 40000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned GAP_CYCLES   = 1000
) (
    input logic                 clk,
    input logic                 reset,
    sd_cmd_scheduler_if.master  bus
);
    localparam int unsigned TW = ($clog2(RESP_TIMEOUT + 1) > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam int unsigned GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_SEND = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;
    localparam logic [2:0] S_RETRY_GAP = 3'd5;
    localparam logic [2:0] S_COMPLETE  = 3'd6;
    localparam logic [2:0] S_GAP       = 3'd7;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_CRC  = 2'b01;
    localparam logic [1:0] ST_TOUT = 2'b10;
    localparam logic [1:0] RT_NONE = 2'b00;
    localparam logic [1:0] RT_R2   = 2'b10;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [GW-1:0] gap_q, gap_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          seen_q, seen_d;
    logic [1:0]    code_q, code_d;
    logic          port_q, port_d;
    logic          last_grant_q, last_grant_d;
    logic [37:0]   cmd_q, cmd_d;
    logic [1:0]    rtype_q, rtype_d;
    logic          r2_q, r2_d;
    logic [126:0]  resp_q, resp_d;
    logic [1:0]    status_q, status_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    ack_q, ack_d;
    logic          send_en_q, send_en_d;
    logic          grant_c;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        retry_d      = retry_q;
        seen_d       = seen_q;
        code_d       = code_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        rtype_d      = rtype_q;
        r2_d         = r2_q;
        resp_d       = resp_q;
        status_d     = status_q;
        done_d       = 2'b00;
        ack_d        = 2'b00;
        send_en_d    = 1'b0;
        grant_c      = 1'b0;
        timer_inc    = (timer_q == TW'(RESP_TIMEOUT)) ? timer_q : timer_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    // On a tie the port that did not win last time is served
                    grant_c      = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
                    port_d       = grant_c;
                    last_grant_d = grant_c;
                    cmd_d        = grant_c ? bus.req_cmd[75:38] : bus.req_cmd[37:0];
                    rtype_d      = grant_c ? bus.req_rtype[3:2] : bus.req_rtype[1:0];
                    r2_d         = (rtype_d == RT_R2);
                    retry_d      = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                seen_d  = 1'b0;
                state_d = S_WAIT_SEND;
            end
            S_WAIT_SEND: begin
                seen_d = seen_q | bus.sd_cmd_sending;
                if (seen_q && !bus.sd_cmd_sending) begin
                    if (rtype_q == RT_NONE) begin
                        code_d  = ST_OK;
                        state_d = S_COMPLETE;
                    end else begin
                        timer_d = '0;
                        state_d = S_WAIT_RESP;
                    end
                end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
                    code_d  = ST_TOUT;
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_WAIT_RESP: begin
                // A response landing in the expiry cycle still counts
                if (bus.sd_receive_finished) begin
                    if (bus.crc_response_err) begin
                        code_d  = ST_CRC;
                        state_d = S_FAIL;
                    end else begin
                        resp_d  = bus.response;
                        code_d  = ST_OK;
                        state_d = S_COMPLETE;
                    end
                end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
                    code_d  = ST_TOUT;
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_FAIL: begin
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    gap_d   = '0;
                    state_d = S_RETRY_GAP;
                end else begin
                    state_d = S_COMPLETE;
                end
            end
            S_RETRY_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_COMPLETE: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered decodes of the state being entered
        send_en_d = (state_d == S_ISSUE);
        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            ack_d = port_d ? 2'b10 : 2'b01;
        end
        if (state_d == S_COMPLETE) begin
            done_d   = port_d ? 2'b10 : 2'b01;
            status_d = code_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            gap_q        <= '0;
            retry_q      <= '0;
            seen_q       <= 1'b0;
            code_q       <= ST_OK;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_q        <= '0;
            rtype_q      <= RT_NONE;
            r2_q         <= 1'b0;
            resp_q       <= '0;
            status_q     <= ST_OK;
            done_q       <= 2'b00;
            ack_q        <= 2'b00;
            send_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            retry_q      <= retry_d;
            seen_q       <= seen_d;
            code_q       <= code_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            rtype_q      <= rtype_d;
            r2_q         <= r2_d;
            resp_q       <= resp_d;
            status_q     <= status_d;
            done_q       <= done_d;
            ack_q        <= ack_d;
            send_en_q    <= send_en_d;
        end
    end

    assign bus.req_ack          = ack_q;
    assign bus.done             = done_q;
    assign bus.status           = status_q;
    assign bus.resp_out         = resp_q;
    assign bus.send_en          = send_en_q;
    assign bus.send_cmd_content = cmd_q;
    assign bus.R2_response      = r2_q;
endmodule
